// File: rtl/arbitro_destino.sv
// Two-VC to two-destination arbiter: VC0 has priority, with a bounded starvation
// counter that hands one grant to VC1 after STARVE_MAX consecutive VC0 wins.
module arbitro_destino #(
    parameter int STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       enable,
    input  logic [5:0] vc0_data,
    input  logic       vc0_empty,
    input  logic [5:0] vc1_data,
    input  logic       vc1_empty,
    input  logic       d0_almost_full,
    input  logic       d1_almost_full,
    output logic       pop_vc0,
    output logic       pop_vc1,
    output logic       push_d0,
    output logic       push_d1,
    output logic [5:0] data_d0,
    output logic [5:0] data_d1,
    output logic [3:0] grant_vc1_cnt
);

    localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

    logic       w_vc0_elig;
    logic       w_vc1_elig;
    logic       w_vc0_dst_af;
    logic       w_vc1_dst_af;
    logic       w_pick_vc1;
    logic [5:0] w_word;
    logic       w_pop;

    logic       r_push_d0;
    logic       r_push_d1;
    logic [5:0] r_data_d0;
    logic [5:0] r_data_d1;
    logic [3:0] r_cnt;

    assign w_vc0_dst_af = vc0_data[4] ? d1_almost_full : d0_almost_full;
    assign w_vc1_dst_af = vc1_data[4] ? d1_almost_full : d0_almost_full;

    // reset_L is folded in so the pop strobes drop immediately on reset assertion
    assign w_vc0_elig = reset_L & enable & ~vc0_empty & ~w_vc0_dst_af;
    assign w_vc1_elig = reset_L & enable & ~vc1_empty & ~w_vc1_dst_af;

    assign w_pick_vc1 = w_vc1_elig & (~w_vc0_elig | (r_cnt == CNT_MAX));

    assign pop_vc1 = w_pick_vc1;
    assign pop_vc0 = w_vc0_elig & ~w_pick_vc1;
    assign w_pop   = pop_vc0 | pop_vc1;
    assign w_word  = pop_vc1 ? vc1_data : vc0_data;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_push_d0 <= 1'b0;
            r_push_d1 <= 1'b0;
            r_data_d0 <= 6'b0;
            r_data_d1 <= 6'b0;
        end else begin
            r_push_d0 <= w_pop & ~w_word[4];
            r_push_d1 <= w_pop &  w_word[4];
            if (w_pop & ~w_word[4]) r_data_d0 <= w_word;
            if (w_pop &  w_word[4]) r_data_d1 <= w_word;
        end
    end

    // Counts only VC0 wins that actually denied an eligible VC1
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_cnt <= 4'd0;
        end else if (pop_vc1) begin
            r_cnt <= 4'd0;
        end else if (pop_vc0) begin
            if (!w_vc1_elig)
                r_cnt <= 4'd0;
            else if (r_cnt < CNT_MAX)
                r_cnt <= r_cnt + 4'd1;
        end
    end

    assign push_d0       = r_push_d0;
    assign push_d1       = r_push_d1;
    assign data_d0       = r_data_d0;
    assign data_d1       = r_data_d1;
    assign grant_vc1_cnt = r_cnt;

endmodule

// File: tb/tb_arbitro_destino.sv
// Directed bench for arbitro_destino: table of per-cycle vectors plus reset corner sequences.
module tb_arbitro_destino;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       enable;
    logic [5:0] vc0_data, vc1_data;
    logic       vc0_empty, vc1_empty;
    logic       d0_almost_full, d1_almost_full;
    logic       pop_vc0, pop_vc1, push_d0, push_d1;
    logic [5:0] data_d0, data_d1;
    logic [3:0] grant_vc1_cnt;

    int errors = 0;
    int checks = 0;

    arbitro_destino #(.STARVE_MAX(4)) dut (
        .clk(clk), .reset_L(reset_L), .enable(enable),
        .vc0_data(vc0_data), .vc0_empty(vc0_empty),
        .vc1_data(vc1_data), .vc1_empty(vc1_empty),
        .d0_almost_full(d0_almost_full), .d1_almost_full(d1_almost_full),
        .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
        .push_d0(push_d0), .push_d1(push_d1),
        .data_d0(data_d0), .data_d1(data_d1),
        .grant_vc1_cnt(grant_vc1_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [5:0] w0;
        logic       e0;
        logic [5:0] w1;
        logic       e1;
        logic       af0;
        logic       af1;
        logic [1:0] pop;   // {pop_vc0, pop_vc1} during the cycle
        logic [1:0] push;  // {push_d0, push_d1} after the edge
        logic [5:0] q0;
        logic [5:0] q1;
        logic [3:0] cnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic en, logic [5:0] w0, logic e0, logic [5:0] w1, logic e1,
                                logic af0, logic af1, logic [1:0] pop, logic [1:0] push,
                                logic [5:0] q0, logic [5:0] q1, logic [3:0] cnt);
        vec_t v;
        v.en = en; v.w0 = w0; v.e0 = e0; v.w1 = w1; v.e1 = e1;
        v.af0 = af0; v.af1 = af1; v.pop = pop; v.push = push;
        v.q0 = q0; v.q1 = q1; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic en, logic [5:0] w0, logic e0, logic [5:0] w1, logic e1,
                         logic af0, logic af1);
        enable = en; vc0_data = w0; vc0_empty = e0; vc1_data = w1; vc1_empty = e1;
        d0_almost_full = af0; d1_almost_full = af1;
    endtask

    task automatic chk_regs(string name, logic [1:0] push, logic [5:0] q0, logic [5:0] q1,
                            logic [3:0] cnt);
        chk(name, 32'({push_d0, push_d1, data_d0, data_d1, grant_vc1_cnt}),
                  32'({push, q0, q1, cnt}));
    endtask

    initial begin
        reset_L = 1'b0;
        drive(1'b1, 6'h05, 1'b0, 6'h07, 1'b0, 1'b0, 1'b0);

        // Routing, idle hold
        vq.push_back(mk(1, 6'h1B, 0, 6'h00, 1, 0, 0, 2'b10, 2'b01, 6'h00, 6'h1B, 4'd0));
        vq.push_back(mk(1, 6'h00, 1, 6'h00, 1, 0, 0, 2'b00, 2'b00, 6'h00, 6'h1B, 4'd0));
        // Starvation: four VC0 wins, then VC1 once
        vq.push_back(mk(1, 6'h05, 0, 6'h07, 0, 0, 0, 2'b10, 2'b10, 6'h05, 6'h1B, 4'd1));
        vq.push_back(mk(1, 6'h05, 0, 6'h07, 0, 0, 0, 2'b10, 2'b10, 6'h05, 6'h1B, 4'd2));
        vq.push_back(mk(1, 6'h05, 0, 6'h07, 0, 0, 0, 2'b10, 2'b10, 6'h05, 6'h1B, 4'd3));
        vq.push_back(mk(1, 6'h05, 0, 6'h07, 0, 0, 0, 2'b10, 2'b10, 6'h05, 6'h1B, 4'd4));
        vq.push_back(mk(1, 6'h05, 0, 6'h07, 0, 0, 0, 2'b01, 2'b10, 6'h07, 6'h1B, 4'd0));
        vq.push_back(mk(1, 6'h05, 0, 6'h07, 0, 0, 0, 2'b10, 2'b10, 6'h05, 6'h1B, 4'd1));
        // Backpressure on D0 blocks VC0
        vq.push_back(mk(1, 6'h05, 0, 6'h11, 0, 1, 0, 2'b01, 2'b01, 6'h05, 6'h11, 4'd0));
        vq.push_back(mk(1, 6'h05, 0, 6'h11, 0, 1, 0, 2'b01, 2'b01, 6'h05, 6'h11, 4'd0));
        vq.push_back(mk(1, 6'h05, 0, 6'h11, 0, 0, 0, 2'b10, 2'b10, 6'h05, 6'h11, 4'd1));
        // Enable gating: counter holds while idle, pops resume same cycle
        vq.push_back(mk(0, 6'h05, 0, 6'h11, 0, 0, 0, 2'b00, 2'b00, 6'h05, 6'h11, 4'd1));
        vq.push_back(mk(1, 6'h05, 0, 6'h11, 0, 0, 0, 2'b10, 2'b10, 6'h05, 6'h11, 4'd2));
        // VC0 win with VC1 not eligible clears the counter
        vq.push_back(mk(1, 6'h05, 0, 6'h11, 1, 0, 0, 2'b10, 2'b10, 6'h05, 6'h11, 4'd0));
        // Drain sequence
        vq.push_back(mk(1, 6'h0D, 0, 6'h00, 1, 0, 0, 2'b10, 2'b10, 6'h0D, 6'h11, 4'd0));
        vq.push_back(mk(1, 6'h03, 0, 6'h00, 1, 0, 0, 2'b10, 2'b10, 6'h03, 6'h11, 4'd0));
        vq.push_back(mk(1, 6'h1A, 0, 6'h00, 1, 0, 0, 2'b10, 2'b01, 6'h03, 6'h1A, 4'd0));
        vq.push_back(mk(1, 6'h00, 1, 6'h00, 1, 0, 0, 2'b00, 2'b00, 6'h03, 6'h1A, 4'd0));
        // D1 full blocks a D1-bound VC0 head; VC1 (to D0) takes the slot
        vq.push_back(mk(1, 6'h1A, 0, 6'h05, 0, 0, 1, 2'b01, 2'b10, 6'h05, 6'h1A, 4'd0));
        vq.push_back(mk(1, 6'h1A, 0, 6'h06, 0, 1, 1, 2'b00, 2'b00, 6'h05, 6'h1A, 4'd0));

        // Reset state, with eligible-looking inputs present
        #12;
        chk("reset_outputs", 32'({pop_vc0, pop_vc1, push_d0, push_d1, data_d0, data_d1, grant_vc1_cnt}), 32'd0);

        @(negedge clk);
        reset_L = 1'b1;
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].en, vq[i].w0, vq[i].e0, vq[i].w1, vq[i].e1, vq[i].af0, vq[i].af1);
            #1;
            chk($sformatf("vec%0d_pop", i), 32'({pop_vc0, pop_vc1}), 32'(vq[i].pop));
            @(posedge clk);
            #1;
            chk_regs($sformatf("vec%0d_regs", i), vq[i].push, vq[i].q0, vq[i].q1, vq[i].cnt);
            @(negedge clk);
        end

        // Reset one cycle after a pop: push visible, then cleared asynchronously
        drive(1'b1, 6'h1B, 1'b0, 6'h00, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("pre_reset_push_d1", 32'(push_d1), 32'd1);
        #1 reset_L = 1'b0;
        #1;
        chk("async_reset_clear", 32'({pop_vc0, pop_vc1, push_d0, push_d1, data_d0, data_d1, grant_vc1_cnt}), 32'd0);
        @(posedge clk);
        #1;
        chk("reset_hold", 32'({push_d0, push_d1, data_d0, data_d1}), 32'd0);

        // First pop allowed in the first cycle after release
        @(negedge clk);
        drive(1'b1, 6'h0D, 1'b0, 6'h00, 1'b1, 1'b0, 1'b0);
        reset_L = 1'b1;
        #1;
        chk("release_pop", 32'({pop_vc0, pop_vc1}), 32'b10);
        @(posedge clk);
        #1;
        chk_regs("release_push", 2'b10, 6'h0D, 6'h00, 4'd0);

        // Reset asserted while a pop is pending: pop drops, nothing pushed
        @(negedge clk);
        drive(1'b1, 6'h1B, 1'b0, 6'h00, 1'b1, 1'b0, 1'b0);
        #1;
        chk("inflight_pop", 32'(pop_vc0), 32'd1);
        #1 reset_L = 1'b0;
        #1;
        chk("inflight_pop_gated", 32'({pop_vc0, pop_vc1}), 32'd0);
        @(posedge clk);
        #1;
        chk("inflight_discarded", 32'({push_d0, push_d1, data_d0, data_d1}), 32'd0);
        @(negedge clk);
        drive(1'b1, 6'h00, 1'b1, 6'h00, 1'b1, 1'b0, 1'b0);
        reset_L = 1'b1;
        @(posedge clk);
        #1;
        chk("no_push_after_release", 32'({push_d0, push_d1}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
